rca_adder_32bit: RTL and testbench

32-bit ripple-carry adder with a registered output stage. It computes in1 + in2 + cin through a chain of 32 single-bit full adders and captures the 32-bit sum and carry-out in registers on the clock edge. It is used as the baseline adder in the datapath, for comparison against carry-lookahead variants. A valid flag travels alongside the data so that downstream logic can qualify the result.

---
 rtl/rca_adder_32bit_pkg.sv | 4 +
 rtl/rca_adder_32bit_full_adder.sv | 11 +
 rtl/rca_adder_32bit.sv | 46 ++++
 tb/tb_rca_adder_32bit.sv | 150 +++++++++++++++
 4 files changed

// File: rtl/rca_adder_32bit_pkg.sv
// Shared constants for the ripple-carry adder slice.
package rca_adder_32bit_pkg;
  localparam int unsigned ADDER_WIDTH = 32;
endpackage

// File: rtl/rca_adder_32bit_full_adder.sv
// Single-bit full adder cell; one stage of the ripple chain.
module full_adder (
  input  logic a,
  input  logic b,
  input  logic ci,
  output logic s,
  output logic co
);
  assign s  = a ^ b ^ ci;
  assign co = (a & b) | (a & ci) | (b & ci);
endmodule

// File: rtl/rca_adder_32bit.sv
// 32-bit ripple-carry adder: full-adder chain feeding a registered sum/cout/valid stage.
module rca_adder_32bit
  import rca_adder_32bit_pkg::*;
#(
  parameter int unsigned WIDTH = ADDER_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in1,
  input  logic [WIDTH-1:0] in2,
  input  logic             cin,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             out_valid
);
  logic [WIDTH:0]   c;
  logic [WIDTH-1:0] s;

  assign c[0] = cin;

  for (genvar i = 0; i < WIDTH; i++) begin : g_chain
    full_adder u_fa (
      .a  (in1[i]),
      .b  (in2[i]),
      .ci (c[i]),
      .s  (s[i]),
      .co (c[i+1])
    );
  end

  // Data registers only load on in_valid, so operand X while idle never reaches sum/cout.
  always_ff @(posedge clk) begin
    if (rst) begin
      sum       <= '0;
      cout      <= 1'b0;
      out_valid <= 1'b0;
    end else if (in_valid) begin
      sum       <= s;
      cout      <= c[WIDTH];
      out_valid <= 1'b1;
    end else begin
      out_valid <= 1'b0;
    end
  end
endmodule

// File: tb/tb_rca_adder_32bit.sv
// Scoreboard bench for rca_adder_32bit: directed vectors plus random traffic against a 33-bit reference.
module tb_rca_adder_32bit;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        in_valid = 1'b0;
  logic [31:0] in1 = '0;
  logic [31:0] in2 = '0;
  logic        cin = 1'b0;
  logic [31:0] sum;
  logic        cout;
  logic        out_valid;

  int checks = 0;
  int failures = 0;

  typedef struct {
    logic        valid;
    logic [31:0] sum;
    logic        cout;
    string       tag;
  } exp_t;

  exp_t sb[$];

  logic [31:0] last_sum = '0;
  logic        last_cout = 1'b0;

  rca_adder_32bit #(.WIDTH(32)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in1       (in1),
    .in2       (in2),
    .cin       (cin),
    .sum       (sum),
    .cout      (cout),
    .out_valid (out_valid)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  // Directed cycle with hand-computed expectations for the result one cycle later.
  task automatic drive(input logic r, input logic v, input logic [31:0] a, input logic [31:0] b,
                       input logic ci, input logic ev, input logic [31:0] es, input logic ec,
                       input string tag);
    exp_t e;
    @(negedge clk);
    rst = r; in_valid = v; in1 = a; in2 = b; cin = ci;
    e.valid = ev; e.sum = es; e.cout = ec; e.tag = tag;
    sb.push_back(e);
    last_sum = es; last_cout = ec;
  endtask

  // Random cycle: expectation from an independent 33-bit addition and hold model.
  task automatic drive_rand(input int idx);
    exp_t e;
    logic [32:0] ref33;
    logic        v;
    logic        r;
    @(negedge clk);
    r = ($urandom_range(0, 99) == 0);
    v = $urandom_range(0, 3) != 0;
    rst = r; in_valid = v;
    in1 = $urandom; in2 = $urandom; cin = 1'($urandom_range(0, 1));
    if ($urandom_range(0, 7) == 0) begin
      in1 = 32'hFFFF_FFFF; in2 = 32'($urandom_range(0, 1));
    end
    ref33 = {1'b0, in1} + {1'b0, in2} + {32'd0, cin};
    if (r) begin
      last_sum = '0; last_cout = 1'b0; e.valid = 1'b0;
    end else if (v) begin
      last_sum = ref33[31:0]; last_cout = ref33[32]; e.valid = 1'b1;
    end else begin
      e.valid = 1'b0;
    end
    e.sum = last_sum; e.cout = last_cout;
    e.tag = $sformatf("rand%0d", idx);
    sb.push_back(e);
  endtask

  // Monitor: each cycle's expectation is consumed just after the edge that produced it.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (sb.size() > 0) begin
        e = sb.pop_front();
        checks++;
        if (out_valid !== e.valid) begin
          failures++;
          $display("FAIL %s out_valid: actual=%b required=%b", e.tag, out_valid, e.valid);
        end
        checks++;
        if (sum !== e.sum) begin
          failures++;
          $display("FAIL %s sum: actual=%0d required=%0d", e.tag, sum, e.sum);
        end
        checks++;
        if (cout !== e.cout) begin
          failures++;
          $display("FAIL %s cout: actual=%b required=%b", e.tag, cout, e.cout);
        end
      end else if (out_valid === 1'b1) begin
        checks++;
        failures++;
        $display("FAIL unexpected_valid: actual=%b required=0", out_valid);
      end
    end
  end

  initial begin
    int drain;
    drive(1, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0, "reset0");
    drive(1, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0, "reset1");
    drive(0, 0, 32'd0, 32'd0, 0, 0, 32'd0, 0, "post_reset");
    drive(0, 1, 32'd4036, 32'd2917, 0, 1, 32'd6953, 0, "small_add");
    drive(0, 1, 32'd51304235, 32'd27042297, 1, 1, 32'd78346533, 0, "b2b_0");
    drive(0, 1, 32'd323052082, 32'd493245026, 0, 1, 32'd816297108, 0, "b2b_1");
    drive(0, 1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1, 1, 32'hFFFF_FFFF, 1, "ones_ones_1");
    drive(0, 1, 32'hFFFF_FFFF, 32'd0, 1, 1, 32'd0, 1, "full_ripple");
    drive(0, 0, 32'h1234_5678, 32'h9ABC_DEF0, 1, 0, 32'd0, 1, "idle_hold");
    drive(0, 1, 32'd0, 32'd0, 0, 1, 32'd0, 0, "zero_add");
    drive(0, 1, 32'h8000_0000, 32'h8000_0000, 0, 1, 32'd0, 1, "msb_overflow");
    drive(1, 1, 32'd5, 32'd5, 0, 0, 32'd0, 0, "rst_with_valid");
    drive(0, 0, 32'd7, 32'd9, 1, 0, 32'd0, 0, "after_rst_idle");
    for (int i = 0; i < 10000; i++) drive_rand(i);
    @(negedge clk);
    in_valid = 1'b0; rst = 1'b0;
    drain = 0;
    while (sb.size() > 0 && drain < 20) begin
      @(posedge clk);
      drain++;
    end
    #2;
    if (sb.size() > 0) begin
      checks++;
      failures++;
      $display("FAIL drain: actual=%0d pending required=0", sb.size());
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
